lamp_conflict_monitor: RTL

LAMP_CONFLICT_MONITOR -- requirements
Module: lamp_conflict_monitor

---
 rtl/lamp_conflict_monitor.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/lamp_conflict_monitor.sv
// Safety monitor between the traffic sequencer and the lamp drivers: passes legal
// lamp commands through, filters short glitches, and falls back to flashing yellow.
module lamp_conflict_monitor #(
  parameter int PRESCALE    = 4,
  parameter int FLASH_TICKS = 2,
  parameter int FILTER      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] road1_in,
  input  logic [2:0] road2_in,
  input  logic       fault_clr,
  output logic [2:0] lamp1_out,
  output logic [2:0] lamp2_out,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic       hold_ctrl,
  output logic [3:0] fault_cnt
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int TW = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
  localparam int FW = $clog2(FILTER + 1);

  localparam logic [2:0] LAMP_RED = 3'b001;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  typedef enum logic [1:0] {PASS, SUSPECT, FLASH} state_t;

  state_t          r_state;
  logic [FW-1:0]   r_filt;
  logic [PW-1:0]   r_presc;
  logic [TW-1:0]   r_tcnt;
  logic            r_phase;
  logic [2:0]      r_lamp1;
  logic [2:0]      r_lamp2;
  logic            r_fault;
  logic [1:0]      r_code;
  logic            r_hold;
  logic [3:0]      r_cnt;

  logic       w_legal1;
  logic       w_legal2;
  logic       w_conflict;
  logic [1:0] w_code;
  logic       w_err;
  logic       w_enter;
  logic       w_tick;
  logic       w_clear;

  assign w_legal1   = $onehot(road1_in);
  assign w_legal2   = $onehot(road2_in);
  assign w_conflict = w_legal1 && w_legal2 && (road1_in != LAMP_RED) && (road2_in != LAMP_RED);

  always_comb begin
    w_code = 2'b00;
    if (w_conflict)     w_code = 2'b11;
    else if (!w_legal1) w_code = 2'b01;
    else if (!w_legal2) w_code = 2'b10;
  end

  assign w_err   = (w_code != 2'b00);
  // FILTER-th consecutive erroneous sample; a filter of 1 trips straight from PASS
  assign w_enter = w_err && (((r_state == PASS) && (FILTER <= 1)) ||
                             ((r_state == SUSPECT) && (r_filt >= FW'(FILTER - 1))));
  assign w_tick  = (r_presc == PW'(PRESCALE - 1));
  assign w_clear = fault_clr && (road1_in == LAMP_RED) && (road2_in == LAMP_RED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= PASS;
      r_filt  <= '0;
      r_presc <= '0;
      r_tcnt  <= '0;
      r_phase <= 1'b0;
      r_lamp1 <= LAMP_RED;
      r_lamp2 <= LAMP_RED;
      r_fault <= 1'b0;
      r_code  <= 2'b00;
      r_hold  <= 1'b0;
      r_cnt   <= 4'd0;
    end else if (w_enter) begin
      r_state <= FLASH;
      r_filt  <= '0;
      r_presc <= '0;
      r_tcnt  <= '0;
      r_phase <= 1'b0;
      r_lamp1 <= LAMP_YEL;
      r_lamp2 <= LAMP_YEL;
      r_fault <= 1'b1;
      r_code  <= w_code;
      r_hold  <= 1'b1;
      if (r_cnt != 4'hF) r_cnt <= r_cnt + 4'd1;
    end else begin
      case (r_state)
        PASS: begin
          if (w_err) begin
            r_state <= SUSPECT;
            r_filt  <= FW'(1);
          end else begin
            r_lamp1 <= road1_in;
            r_lamp2 <= road2_in;
          end
        end
        SUSPECT: begin
          if (w_err) begin
            r_filt <= r_filt + FW'(1);
          end else begin
            r_state <= PASS;
            r_filt  <= '0;
            r_lamp1 <= road1_in;
            r_lamp2 <= road2_in;
          end
        end
        FLASH: begin
          if (w_clear) begin
            r_state <= PASS;
            r_filt  <= '0;
            r_presc <= '0;
            r_tcnt  <= '0;
            r_phase <= 1'b0;
            r_lamp1 <= LAMP_RED;
            r_lamp2 <= LAMP_RED;
            r_fault <= 1'b0;
            r_code  <= 2'b00;
            r_hold  <= 1'b0;
          end else if (w_tick) begin
            r_presc <= '0;
            if (r_tcnt == TW'(FLASH_TICKS - 1)) begin
              // r_phase=1 means the dark half-period is running
              r_tcnt  <= '0;
              r_phase <= ~r_phase;
              r_lamp1 <= r_phase ? LAMP_YEL : LAMP_OFF;
              r_lamp2 <= r_phase ? LAMP_YEL : LAMP_OFF;
            end else begin
              r_tcnt <= r_tcnt + TW'(1);
            end
          end else begin
            r_presc <= r_presc + PW'(1);
          end
        end
        default: r_state <= PASS;
      endcase
    end
  end

  assign lamp1_out  = r_lamp1;
  assign lamp2_out  = r_lamp2;
  assign fault      = r_fault;
  assign fault_code = r_code;
  assign hold_ctrl  = r_hold;
  assign fault_cnt  = r_cnt;

endmodule
